// File: rtl/midi_button_ctrl.sv
// midi_button_ctrl
//   Two-button MIDI controller. Each button is debounced. A press sends Note On
//   and a release sends Note Off, on a 31250-baud 8N1 serial line. Incoming
//   MIDI is decoded so that status bytes can blink an LED.
//
//   Ports
//     clk      system clock
//     rst      synchronous reset, active high
//     btn1/2   asynchronous buttons, high = pressed
//     midi_rx  asynchronous MIDI serial in, idle high
//     midi_tx  MIDI serial out, idle high (registered)
//     led1     high while a message is on the wire
//     led2     toggles on each valid status byte (0x80..0xF7) received
//
//   Build option
//     MIDI_RUNNING_STATUS_EN: the status byte is dropped when it repeats the
//     previously transmitted status.

// Per-button synchronizer and debouncer.
module midi_btn_debounce #(
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db
);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  logic [1:0]    sync;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      // Any return to the accepted level restarts the stability window.
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CNT - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end
endmodule

module midi_button_ctrl #(
  parameter int         BAUD_CNT_HALF = 800,
  parameter int         DEBOUNCE_CNT  = 500000,
  parameter int         CHANNEL       = 0,
  parameter logic [7:0] NOTE1         = 8'h3C,
  parameter logic [7:0] NOTE2         = 8'h3E,
  parameter logic [7:0] VELOCITY      = 8'h64
) (
  input  logic rst,
  input  logic clk,
  input  logic btn1,
  input  logic btn2,
  input  logic midi_rx,
  output logic midi_tx,
  output logic led1,
  output logic led2
);
  localparam int              NUM_BTN   = 2;
  localparam int              BW        = $clog2(2 * BAUD_CNT_HALF + 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(2 * BAUD_CNT_HALF - 1);
  localparam logic [BW-1:0]   HALF_LAST = BW'(BAUD_CNT_HALF - 1);
  localparam logic [3:0]      CH        = 4'(CHANNEL);

  // ---------------------------------------------------------------- buttons
  logic [NUM_BTN-1:0] btn_in, db, last_sent, pend;

  assign btn_in = {btn2, btn1};

  midi_btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db [NUM_BTN-1:0] (
    .clk (clk),
    .rst (rst),
    .btn (btn_in),
    .db  (db)
  );

  // Level-based scheduling: only the difference between debounced and last
  // announced level matters, so a press+release inside a busy frame vanishes.
  assign pend = db ^ last_sent;

  logic       sel, lvl;
  logic [7:0] msg_status, msg_note, msg_vel;

  always_comb begin
    sel        = ~pend[0];            // btn1 wins when both are pending
    lvl        = db[sel];
    msg_status = {lvl ? 4'h9 : 4'h8, CH};
    msg_note   = sel ? NOTE2 : NOTE1;
    msg_vel    = lvl ? VELOCITY : 8'h00;
  end

  // --------------------------------------------------------------------- TX
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t      tx_st;
  logic [BW-1:0]  tx_cnt;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_byte;
  logic [15:0]    tx_rest;   // bytes still to send, next one in [7:0]
  logic [1:0]     tx_left;   // number of valid bytes in tx_rest
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0]     last_status;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st     <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_byte   <= '0;
      tx_rest   <= '0;
      tx_left   <= '0;
      last_sent <= '0;
      midi_tx   <= 1'b1;
      led1      <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status <= 8'h00;
`endif
    end else begin
      case (tx_st)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (|pend) begin
            last_sent[sel] <= lvl;
`ifdef MIDI_RUNNING_STATUS_EN
            if (msg_status == last_status) begin
              tx_byte <= msg_note;
              tx_rest <= {8'h00, msg_vel};
              tx_left <= 2'd1;
            end else begin
              tx_byte <= msg_status;
              tx_rest <= {msg_vel, msg_note};
              tx_left <= 2'd2;
            end
            last_status <= msg_status;
`else
            tx_byte <= msg_status;
            tx_rest <= {msg_vel, msg_note};
            tx_left <= 2'd2;
`endif
            midi_tx <= 1'b0;
            led1    <= 1'b1;
            tx_st   <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            midi_tx <= tx_byte[0];
            tx_byte <= {1'b0, tx_byte[7:1]};
            tx_st   <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + BW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              midi_tx <= 1'b1;
              tx_st   <= TX_STOP;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              midi_tx <= tx_byte[0];
              tx_byte <= {1'b0, tx_byte[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + BW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_left != 2'd0) begin
              // Next byte of the same message follows with no idle gap.
              tx_byte <= tx_rest[7:0];
              tx_rest <= {8'h00, tx_rest[15:8]};
              tx_left <= tx_left - 2'd1;
              midi_tx <= 1'b0;
              tx_st   <= TX_START;
            end else begin
              led1  <= 1'b0;
              tx_st <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + BW'(1);
          end
        end
        default: begin
          tx_st   <= TX_IDLE;
          midi_tx <= 1'b1;
          led1    <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  rx_state_t     rx_st;
  logic [2:0]    rx_sync;   // [1] is the synced line, [2] its previous value
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rxd, rx_prev;

  assign rxd     = rx_sync[1];
  assign rx_prev = rx_sync[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st   <= RX_HUNT;
      rx_sync <= 3'b111;    // idle level, so a line held low reads as a start
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      led2    <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], midi_rx};
      case (rx_st)
        RX_HUNT: begin
          rx_cnt <= '0;
          if (rx_prev && !rxd) rx_st <= RX_START;
        end
        RX_START: begin
          // Half a bit after the falling edge: reject glitches.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rxd ? RX_HUNT : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rxd, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
            else                rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rxd) begin
              if (rx_sh[7] && rx_sh < 8'hF8) led2 <= ~led2;
              rx_st <= RX_HUNT;
            end else begin
              rx_st <= RX_WAIT_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end
        RX_WAIT_IDLE: begin
          // Require one full bit period of idle before hunting again.
          if (!rxd) begin
            rx_cnt <= '0;
          end else if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_st  <= RX_HUNT;
          end else begin
            rx_cnt <= rx_cnt + BW'(1);
          end
        end
        default: rx_st <= RX_HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_midi_button_ctrl.sv
module tb_midi_button_ctrl;
  localparam int H   = 32;
  localparam int D   = 10;
  localparam int BIT = 2 * H;

  logic clk = 1'b0, rst = 1'b1, btn1 = 1'b0, btn2 = 1'b0, midi_rx = 1'b0;
  logic midi_tx, led1, led2;

  midi_button_ctrl #(.BAUD_CNT_HALF(H), .DEBOUNCE_CNT(D)) dut (
    .rst(rst), .clk(clk), .btn1(btn1), .btn2(btn2), .midi_rx(midi_rx),
    .midi_tx(midi_tx), .led1(led1), .led2(led2)
  );

  always #10 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Serial-line monitor: decodes 8N1 frames on midi_tx into a byte queue.
  logic [7:0] txq[$];
  int         nfalls = 0;
  int         stop_err = 0;
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (!rst && midi_tx === 1'b0) begin
      nfalls++;
      repeat (H) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = midi_tx;
      end
      repeat (BIT) @(negedge clk);
      if (midi_tx !== 1'b1) stop_err++;
      txq.push_back(b);
    end
  end

  // led1 pulse-width monitor.
  int l1q[$];
  int l1cnt = 0;
  always begin
    @(negedge clk);
    if (led1 === 1'b1) l1cnt++;
    else if (l1cnt != 0) begin
      l1q.push_back(l1cnt);
      l1cnt = 0;
    end
  end

  // Reference model: the byte stream and led1 pulse width for each message.
  logic [7:0] expq[$];
  int         explen[$];
  logic [7:0] m_last = 8'h00;

  task automatic model_msg(input int b, input bit lvl);
    logic [7:0] st;
    int n;
    st = lvl ? 8'h90 : 8'h80;
    n  = 2;
`ifdef MIDI_RUNNING_STATUS_EN
    if (st != m_last) begin
      expq.push_back(st);
      n++;
    end
    m_last = st;
`else
    expq.push_back(st);
    n++;
`endif
    expq.push_back(b == 0 ? 8'h3C : 8'h3E);
    expq.push_back(lvl ? 8'h64 : 8'h00);
    explen.push_back(n * 10 * BIT);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for all modelled bytes, then compare bytes and led1 widths in order.
  task automatic drain(input string tag);
    int budget;
    budget = 9000;
    while (txq.size() < expq.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({tag, "_in_time"}, 32'(budget > 0), 32'd1);
    clocks(48);
    chk({tag, "_nbytes"}, 32'(txq.size()), 32'(expq.size()));
    while (txq.size() > 0 && expq.size() > 0)
      chk({tag, "_byte"}, 32'(txq.pop_front()), 32'(expq.pop_front()));
    chk({tag, "_npulse"}, 32'(l1q.size()), 32'(explen.size()));
    while (l1q.size() > 0 && explen.size() > 0)
      chk({tag, "_led1_len"}, 32'(l1q.pop_front()), 32'(explen.pop_front()));
    chk({tag, "_stopbit"}, 32'(stop_err), 32'd0);
    txq.delete(); expq.delete(); l1q.delete(); explen.delete();
  endtask

  task automatic rx_send(input logic [7:0] b, input bit stop);
    midi_rx = 1'b0;
    clocks(BIT);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      clocks(BIT);
    end
    midi_rx = stop;
    clocks(BIT);
    midi_rx = 1'b1;
    clocks(2 * BIT);
  endtask

  initial begin
    bit         exp_led2;
    bit [1:0]   lv;
    int         k, f0, mode, g, o;
    logic [7:0] rb;
    bit         rs;
    logic [7:0] rx_dir[4];

    exp_led2 = 1'b0;
    lv       = 2'b00;

    // Reset with receive line stuck low.
    clocks(5);
    rst = 1'b0;
    clocks(1);
    chk("rst_midi_tx", 32'(midi_tx), 32'd1);
    chk("rst_led1", 32'(led1), 32'd0);
    chk("rst_led2", 32'(led2), 32'd0);
    clocks(2000);
    chk("stuck_led2", 32'(led2), 32'd0);
    chk("stuck_no_tx", 32'(nfalls), 32'd0);
    midi_rx = 1'b1;
    clocks(200);

    // btn1 press: latency and Note On.
    btn1 = 1'b1; lv[0] = 1'b1;
    model_msg(0, 1'b1);
    k = 0;
    while (midi_tx === 1'b1 && k < 40) begin
      clocks(1);
      k++;
    end
    chk("press_latency_le15", 32'(k <= 15), 32'd1);
    drain("press1");

    // btn1 release: Note Off.
    btn1 = 1'b0; lv[0] = 1'b0;
    model_msg(0, 1'b0);
    drain("release1");

    // btn2 press then btn1 press 5 us later while busy.
    btn2 = 1'b1; lv[1] = 1'b1;
    model_msg(1, 1'b1);
    clocks(250);
    btn1 = 1'b1; lv[0] = 1'b1;
    model_msg(0, 1'b1);
    drain("overlap");

    // Simultaneous release: btn1 goes first.
    btn1 = 1'b0; btn2 = 1'b0; lv = 2'b00;
    model_msg(0, 1'b0);
    model_msg(1, 1'b0);
    drain("priority");

    // Short glitch is ignored.
    f0 = nfalls;
    btn1 = 1'b1;
    clocks(5);
    btn1 = 1'b0;
    clocks(400);
    chk("glitch_no_tx", 32'(nfalls), 32'(f0));
    chk("glitch_idle_level", 32'(midi_tx), 32'd1);

    // Randomized button activity.
    for (int it = 0; it < 8; it++) begin
      mode = int'($urandom_range(0, 2));
      if (mode < 2) begin
        o = 1 - mode;
        g = int'($urandom_range(1, D - 2));
        if (o == 0) btn1 = ~lv[0]; else btn2 = ~lv[1];
        clocks(g);
        btn1 = lv[0]; btn2 = lv[1];
        clocks(int'($urandom_range(5, 30)));
      end
      if (mode != 1) begin
        lv[0] = ~lv[0];
        btn1  = lv[0];
      end
      if (mode != 0) begin
        lv[1] = ~lv[1];
        btn2  = lv[1];
      end
      if (mode != 1) model_msg(0, lv[0]);
      if (mode != 0) model_msg(1, lv[1]);
      drain("rand_btn");
    end

    // Receive: directed frames.
    rx_dir[0] = 8'h90; rx_dir[1] = 8'h3C; rx_dir[2] = 8'hF8; rx_dir[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      rx_send(rx_dir[i], 1'b1);
      if (rx_dir[i] >= 8'h80 && rx_dir[i] < 8'hF8) exp_led2 = ~exp_led2;
      chk("rx_dir_led2", 32'(led2), 32'(exp_led2));
    end
    rx_send(8'h90, 1'b0);
    chk("rx_framing_err_led2", 32'(led2), 32'(exp_led2));

    // Receive: random bytes, occasional bad stop bit.
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rx_send(rb, rs);
      if (rs && rb >= 8'h80 && rb < 8'hF8) exp_led2 = ~exp_led2;
      chk("rx_rand_led2", 32'(led2), 32'(exp_led2));
    end

    // Reset in the middle of a frame.
    lv[1] = ~lv[1];
    btn2  = lv[1];
    k = 0;
    while (midi_tx === 1'b1 && k < 40) begin
      clocks(1);
      k++;
    end
    chk("mid_frame_started", 32'(midi_tx), 32'd0);
    clocks(100);
    rst = 1'b1;
    clocks(1);
    chk("mid_rst_midi_tx", 32'(midi_tx), 32'd1);
    chk("mid_rst_led1", 32'(led1), 32'd0);
    btn1 = 1'b0; btn2 = 1'b0;
    clocks(3);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      clocks(1);
      if (midi_tx !== 1'b1) k++;
    end
    chk("mid_rst_no_resume", 32'(k), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
